sync_cnt_nested_if_down: RTL and testbench

- Loadable down-counter/timer. Mirror of the nested-if up-counter: consumes count instead of producing it.
- Step size is chosen by nested conditions: c1 && c2 gives step 2, c1 && !c2 gives step 1, !c1 gives hold.
- A small FSM (IDLE/RUN/DONE) tracks one countdown from load to zero.
- Sits in the CFG/Verilog golden-test set as the counterpart stimulus for nested-if and width-extension lowering.

---
 rtl/sync_cnt_nested_if_down.sv | 111 +++++++++++
 tb/tb_sync_cnt_nested_if_down.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sync_cnt_nested_if_down.sv
// Loadable down-counter/timer with nested-if step select (c1&&c2 -> 2, c1 -> 1, else hold).
// Optional build macro SYNC_CNT_DOWN_WRAP_EN: a borrowing step wraps modulo 2^WIDTH instead of saturating to 0.
module sync_cnt_nested_if_down #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             c1,
  input  logic             c2,
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             borrow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state;
  logic [1:0]     step;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           land_zero;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    step = 2'd0;
    if (c1) begin
      if (c2) step = 2'd2;
      else    step = 2'd1;
    end
  end

  // One extra bit on the left catches the borrow out of the top of the counter.
  assign diff      = {1'b0, cnt_o} - {{(WIDTH-1){1'b0}}, step};
  assign borrow    = diff[WIDTH];
  assign land_zero = (diff[WIDTH-1:0] == '0) && (step != 2'd0);

  // NOTE: state and outputs update with non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt_o    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      borrow_o <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      borrow_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy_o <= 1'b0;
          if (load) begin
            if (load_val != '0) begin
              cnt_o  <= load_val;
              state  <= RUN;
              busy_o <= 1'b1;
            end else begin
              cnt_o  <= '0;
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            // A reload mid-countdown restarts the timer and never applies the pending step.
            if (load_val != '0) begin
              cnt_o  <= load_val;
              busy_o <= 1'b1;
            end else begin
              cnt_o  <= '0;
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end else if (borrow) begin
`ifdef SYNC_CNT_DOWN_WRAP_EN
            cnt_o    <= diff[WIDTH-1:0];
            borrow_o <= 1'b1;
`else
            cnt_o    <= '0;
            borrow_o <= 1'b1;
            done_o   <= 1'b1;
            state    <= DONE;
            busy_o   <= 1'b0;
`endif
          end else if (land_zero) begin
            cnt_o  <= '0;
            done_o <= 1'b1;
            state  <= DONE;
            busy_o <= 1'b0;
          end else begin
            cnt_o <= diff[WIDTH-1:0];
          end
        end
        default: begin
          state  <= IDLE;
          cnt_o  <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_cnt_nested_if_down.sv
// Directed self-checking bench for sync_cnt_nested_if_down (WIDTH=4).
// Expectations follow SYNC_CNT_DOWN_WRAP_EN when it is defined for the build.
module tb_sync_cnt_nested_if_down;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             c1;
  logic             c2;
  logic [WIDTH-1:0] cnt_o;
  logic             busy_o;
  logic             done_o;
  logic             borrow_o;

  int checks = 0;
  int errors = 0;

  sync_cnt_nested_if_down #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .c1       (c1),
    .c2       (c2),
    .cnt_o    (cnt_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .borrow_o (borrow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int cnt, input bit busy, input bit done, input bit brw);
    check({tag, ".cnt"},    32'(cnt_o),    32'(cnt));
    check({tag, ".busy"},   32'(busy_o),   32'(busy));
    check({tag, ".done"},   32'(done_o),   32'(done));
    check({tag, ".borrow"}, 32'(borrow_o), 32'(brw));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; c1 = 1'b0; c2 = 1'b0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // IDLE ignores c1/c2
    c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("idle_hold", 0, 0, 0, 0);

    // Nested step select
    c1 = 1'b0; c2 = 1'b0; load = 1'b1; load_val = 4'd10;
    tick(); check_all("load10", 10, 1, 0, 0);
    load = 1'b0; c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("step2", 8, 1, 0, 0);
    c1 = 1'b1; c2 = 1'b0;
    tick(); check_all("step1", 7, 1, 0, 0);
    c1 = 1'b0; c2 = 1'b1;
    tick(); check_all("hold", 7, 1, 0, 0);

    // Exact zero
    c1 = 1'b0; c2 = 1'b0; load = 1'b1; load_val = 4'd3;
    tick(); check_all("load3", 3, 1, 0, 0);
    load = 1'b0; c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("zero_a", 1, 1, 0, 0);
    c1 = 1'b1; c2 = 1'b0;
    tick(); check_all("zero_b", 0, 0, 1, 0);
    c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("done_stay", 0, 0, 0, 0);

    // Borrow from DONE-reloaded count of 1
    c1 = 1'b0; c2 = 1'b0; load = 1'b1; load_val = 4'd1;
    tick(); check_all("load1", 1, 1, 0, 0);
    load = 1'b0; c1 = 1'b1; c2 = 1'b1;
    tick();
`ifdef SYNC_CNT_DOWN_WRAP_EN
    check_all("borrow_wrap", 15, 1, 0, 1);
    c1 = 1'b0; c2 = 1'b0;
    tick(); check_all("after_wrap", 15, 1, 0, 0);
`else
    check_all("borrow_sat", 0, 0, 1, 1);
    c1 = 1'b0; c2 = 1'b0;
    tick(); check_all("after_sat", 0, 0, 0, 0);
`endif

    // Load priority in RUN, then zero load
    load = 1'b1; load_val = 4'd5;
    tick(); check_all("load5", 5, 1, 0, 0);
    load = 1'b1; load_val = 4'd12; c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("load_prio", 12, 1, 0, 0);
    load = 1'b1; load_val = 4'd0; c1 = 1'b0; c2 = 1'b0;
    tick(); check_all("load_zero", 0, 0, 1, 0);
    load = 1'b0;
    tick(); check_all("load_zero_after", 0, 0, 0, 0);

    // Reset mid-run, asserted between edges
    load = 1'b1; load_val = 4'd9;
    tick(); check_all("load9", 9, 1, 0, 0);
    load = 1'b0; c1 = 1'b1; c2 = 1'b0;
    tick(); check("run9.a", 32'(cnt_o), 32'd8);
    tick(); check("run9.b", 32'(cnt_o), 32'd7);
    tick(); check("run9.c", 32'(cnt_o), 32'd6);
    #2 reset = 1'b1;
    #1 check_all("async_reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0; c1 = 1'b1; c2 = 1'b1;
    tick(); check_all("post_reset_idle", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
